// File: rtl/clk_dcm_seq.sv
// Reset/lock sequencer for the 11->33 MHz clock-multiplier DCM.
// Runs on clk11 (the DCM CLKIN) so it keeps working while the DCM is unlocked.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// RESET     | dcm_rst held high for RST_CYCLES edges
// WAIT_LOCK | waiting for synchronized LOCKED, bounded by LOCK_TIMEOUT
// STABLE    | LOCKED must stay high for STABLE_CYCLES consecutive cycles
// RUN       | sys_rst_n released, ready high; lock loss re-sequences
// FAULT     | retries exhausted; DCM held in reset until fault_clr
module clk_dcm_seq #(
   parameter int RST_CYCLES    = 4,
   parameter int LOCK_TIMEOUT  = 60000,
   parameter int STABLE_CYCLES = 16,
   parameter int MAX_RETRIES   = 7,
   parameter int CNT_W         = 16,
   parameter int RETRY_W       = 3
) (
   input  logic               clk11,
   input  logic               rst_n,
   input  logic               dcm_locked,
   input  logic               fault_clr,
   output logic               dcm_rst,
   output logic               sys_rst_n,
   output logic               ready,
   output logic               fault,
   output logic [RETRY_W-1:0] retry_count,
   output logic [2:0]         state_dbg
);

   typedef enum logic [2:0] {
      S_RESET     = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_STABLE    = 3'd2,
      S_RUN       = 3'd3,
      S_FAULT     = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0]   LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);

   state_t             state, state_nx;
   logic [CNT_W-1:0]   cnt, cnt_nx;
   logic [RETRY_W-1:0] retry_nx;
   logic               locked_m, locked_s;

   always_ff @(posedge clk11 or negedge rst_n) begin
      if (!rst_n) begin
         locked_m <= 1'b0;
         locked_s <= 1'b0;
      end else begin
         locked_m <= dcm_locked;
         locked_s <= locked_m;
      end
   end

   always_ff @(posedge clk11 or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_RESET;
         cnt         <= '0;
         retry_count <= '0;
      end else begin
         state       <= state_nx;
         cnt         <= cnt_nx;
         retry_count <= retry_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt + CNT_W'(1);
      retry_nx = retry_count;
      case (state)
         S_RESET: begin
            if (cnt == RST_LAST) begin
               state_nx = S_WAIT_LOCK;
               cnt_nx   = '0;
            end
         end
         S_WAIT_LOCK: begin
            // a lock seen on the timeout cycle still wins
            if (locked_s) begin
               state_nx = S_STABLE;
               cnt_nx   = '0;
            end else if (cnt == LOCK_LAST) begin
               cnt_nx = '0;
               if (retry_count == RETRY_MAX) begin
                  state_nx = S_FAULT;
               end else begin
                  state_nx = S_RESET;
                  retry_nx = retry_count + RETRY_W'(1);
               end
            end
         end
         S_STABLE: begin
            if (!locked_s) begin
               state_nx = S_WAIT_LOCK;
               cnt_nx   = '0;
            end else if (cnt == STABLE_LAST) begin
               state_nx = S_RUN;
               cnt_nx   = '0;
               retry_nx = '0;
            end
         end
         S_RUN: begin
            cnt_nx = '0;
            if (!locked_s) state_nx = S_RESET;
         end
         S_FAULT: begin
            cnt_nx = '0;
            if (fault_clr) begin
               state_nx = S_RESET;
               retry_nx = '0;
            end
         end
         default: begin
            state_nx = S_RESET;
            cnt_nx   = '0;
            retry_nx = '0;
         end
      endcase
   end

   // outputs decoded from the next state so they move on the same edge as state
   always_ff @(posedge clk11 or negedge rst_n) begin
      if (!rst_n) begin
         dcm_rst   <= 1'b1;
         sys_rst_n <= 1'b0;
         ready     <= 1'b0;
         fault     <= 1'b0;
         state_dbg <= 3'd0;
      end else begin
         dcm_rst   <= (state_nx == S_RESET) || (state_nx == S_FAULT);
         sys_rst_n <= (state_nx == S_RUN);
         ready     <= (state_nx == S_RUN);
         fault     <= (state_nx == S_FAULT);
         state_dbg <= state_nx;
      end
   end

endmodule

// File: tb/tb_clk_dcm_seq.sv
// Bench for clk_dcm_seq: directed scenarios plus random lock/clear activity,
// all outputs compared every cycle against a phase/elapsed-time reference model.
module tb_clk_dcm_seq;

   localparam int RST_CYCLES    = 4;
   localparam int LOCK_TIMEOUT  = 100;
   localparam int STABLE_CYCLES = 8;
   localparam int MAX_RETRIES   = 2;
   localparam int CNT_W         = 16;
   localparam int RETRY_W       = 3;

   localparam int P_RESET = 0, P_WAIT = 1, P_STABLE = 2, P_RUN = 3, P_FAULT = 4;

   logic               clk11 = 1'b0;
   logic               rst_n = 1'b1;
   logic               dcm_locked = 1'b0;
   logic               fault_clr = 1'b0;
   logic               dcm_rst, sys_rst_n, ready, fault;
   logic [RETRY_W-1:0] retry_count;
   logic [2:0]         state_dbg;

   int n_total = 0;
   int n_bad   = 0;
   bit chk_en  = 1'b0;

   always #5 clk11 = ~clk11;

   clk_dcm_seq #(
      .RST_CYCLES(RST_CYCLES), .LOCK_TIMEOUT(LOCK_TIMEOUT), .STABLE_CYCLES(STABLE_CYCLES),
      .MAX_RETRIES(MAX_RETRIES), .CNT_W(CNT_W), .RETRY_W(RETRY_W)
   ) dut (
      .clk11(clk11), .rst_n(rst_n), .dcm_locked(dcm_locked), .fault_clr(fault_clr),
      .dcm_rst(dcm_rst), .sys_rst_n(sys_rst_n), .ready(ready), .fault(fault),
      .retry_count(retry_count), .state_dbg(state_dbg)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // reference model: phase + edges spent in it; sync modelled as a 2-sample delay line
   int m_phase = P_RESET;
   int m_time  = 0;
   int m_retry = 0;
   bit m_hist[$] = '{1'b0, 1'b0};

   always @(posedge clk11 or negedge rst_n) begin
      if (!rst_n) begin
         m_phase = P_RESET;
         m_time  = 0;
         m_retry = 0;
         m_hist  = '{1'b0, 1'b0};
      end else begin : step
         bit ls;
         int nxt;
         ls = m_hist.pop_front();
         m_hist.push_back(dcm_locked);
         m_time++;
         nxt = m_phase;
         case (m_phase)
            P_RESET:  if (m_time == RST_CYCLES) nxt = P_WAIT;
            P_WAIT: begin
               if (ls) nxt = P_STABLE;
               else if (m_time == LOCK_TIMEOUT) begin
                  if (m_retry == MAX_RETRIES) nxt = P_FAULT;
                  else begin m_retry++; nxt = P_RESET; end
               end
            end
            P_STABLE: begin
               if (!ls) nxt = P_WAIT;
               else if (m_time == STABLE_CYCLES) begin m_retry = 0; nxt = P_RUN; end
            end
            P_RUN:    if (!ls) nxt = P_RESET;
            P_FAULT:  if (fault_clr) begin m_retry = 0; nxt = P_RESET; end
            default:  nxt = P_RESET;
         endcase
         if (nxt != m_phase) begin
            m_phase = nxt;
            m_time  = 0;
         end
      end
   end

   always @(negedge clk11) begin
      if (chk_en) begin
         check("m_state", state_dbg, m_phase);
         check("m_dcm_rst", dcm_rst, (m_phase == P_RESET) || (m_phase == P_FAULT));
         check("m_sys_rst_n", sys_rst_n, m_phase == P_RUN);
         check("m_ready", ready, m_phase == P_RUN);
         check("m_fault", fault, m_phase == P_FAULT);
         check("m_retry", retry_count, m_retry);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk11);
      #2;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_dcm_rst"}, dcm_rst, 1);
      check({tag, "_sys_rst_n"}, sys_rst_n, 0);
      check({tag, "_ready"}, ready, 0);
      check({tag, "_fault"}, fault, 0);
      check({tag, "_retry"}, retry_count, 0);
      check({tag, "_state"}, state_dbg, P_RESET);
   endtask

   task automatic do_reset(input string tag);
      @(posedge clk11); #2;
      rst_n = 1'b0;
      #1 check_reset_vals(tag);
      @(posedge clk11); #2;
      rst_n = 1'b1;
   endtask

   task automatic rst_pulse_len(output int n);
      n = 0;
      do begin @(posedge clk11); #1; n++; end while (dcm_rst === 1'b1 && n < 1000);
   endtask

   task automatic ready_after(output int n, input int budget);
      n = 0;
      do begin @(posedge clk11); #1; n++; end while (ready !== 1'b1 && n < budget);
   endtask

   task automatic wait_state(input int s, input int budget, input string tag);
      int n = 0;
      while (state_dbg !== s[2:0] && n < budget) begin @(posedge clk11); #1; n++; end
      check(tag, state_dbg, s);
   endtask

   initial begin
      #100_000_000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", n_total, n_bad);
      $fatal(1);
   end

   initial begin
      int n;
      #1 rst_n = 1'b0;
      #11 chk_en = 1'b1;
      check_reset_vals("t1_por");

      // 1: basic lock
      @(posedge clk11); #2;
      rst_n = 1'b1;
      rst_pulse_len(n);
      check("t1_rst_len", n, RST_CYCLES);
      repeat (20) @(posedge clk11);
      #2 dcm_locked = 1'b1;
      ready_after(n, 100);
      check("t1_latency", n - 1, STABLE_CYCLES + 2);
      check("t1_sys_rst_n", sys_rst_n, 1);
      check("t1_retry", retry_count, 0);

      // 2: one timeout then lock
      dcm_locked = 1'b0;
      do_reset("t2_rst");
      rst_pulse_len(n);
      check("t2_rst_len", n, RST_CYCLES);
      n = 0;
      do begin @(posedge clk11); #1; n++; end while (dcm_rst === 1'b0 && n < 500);
      check("t2_wait_len", n, LOCK_TIMEOUT);
      rst_pulse_len(n);
      check("t2_retry_rst_len", n, RST_CYCLES);
      check("t2_retry1", retry_count, 1);
      tick($urandom_range(5, 60));
      dcm_locked = 1'b1;
      ready_after(n, 100);
      check("t2_ready", ready, 1);
      check("t2_retry0", retry_count, 0);

      // 3: glitch during STABLE
      dcm_locked = 1'b0;
      do_reset("t3_rst");
      tick($urandom_range(1, 30));
      dcm_locked = 1'b1;
      wait_state(P_STABLE, 150, "t3_stable");
      repeat (4) @(posedge clk11);
      #2 dcm_locked = 1'b0;
      @(posedge clk11);
      #2 dcm_locked = 1'b1;
      wait_state(P_WAIT, 10, "t3_back_wait");
      check("t3_no_retry", retry_count, 0);
      ready_after(n, 50);
      check("t3_restable", n, STABLE_CYCLES + 1);

      // 4: no lock -> FAULT, clear, then clear ignored in RUN
      dcm_locked = 1'b0;
      do_reset("t4_rst");
      wait_state(P_FAULT, 3 * (LOCK_TIMEOUT + RST_CYCLES) + 20, "t4_fault_state");
      check("t4_fault", fault, 1);
      check("t4_dcm_rst", dcm_rst, 1);
      check("t4_retry", retry_count, MAX_RETRIES);
      check("t4_sys_rst_n", sys_rst_n, 0);
      tick($urandom_range(3, 10));
      check("t4_hold", state_dbg, P_FAULT);
      fault_clr = 1'b1;
      @(posedge clk11); #1;
      fault_clr = 1'b0;
      check("t4_clr_state", state_dbg, P_RESET);
      check("t4_clr_retry", retry_count, 0);
      check("t4_clr_fault", fault, 0);
      dcm_locked = 1'b1;
      ready_after(n, 100);
      check("t4_ready", ready, 1);
      @(posedge clk11); #2 fault_clr = 1'b1;
      @(posedge clk11); #2 fault_clr = 1'b0;
      check("t4_clr_in_run", state_dbg, P_RUN);
      check("t4_ready_kept", ready, 1);

      // 5: lock loss in RUN
      dcm_locked = 1'b0;
      n = 0;
      do begin @(posedge clk11); #1; n++; end while (ready === 1'b1 && n < 20);
      check("t5_drop_edges", n - 1, 2);
      check("t5_sys_rst_n", sys_rst_n, 0);
      check("t5_dcm_rst", dcm_rst, 1);
      tick($urandom_range(1, 20));
      dcm_locked = 1'b1;
      ready_after(n, 200);
      check("t5_relock", ready, 1);

      // 6: async reset mid-STABLE and mid-RESET
      dcm_locked = 1'b0;
      do_reset("t6_rst");
      dcm_locked = 1'b1;
      wait_state(P_STABLE, 50, "t6_stable");
      tick(3);
      rst_n = 1'b0;
      #1 check_reset_vals("t6_mid_stable");
      @(posedge clk11); #2 rst_n = 1'b1;
      rst_pulse_len(n);
      check("t6_rst_len_a", n, RST_CYCLES);
      do_reset("t6_rst2");
      tick(2);
      rst_n = 1'b0;
      #1 check_reset_vals("t6_mid_reset");
      @(posedge clk11); #2 rst_n = 1'b1;
      rst_pulse_len(n);
      check("t6_rst_len_b", n, RST_CYCLES);
      ready_after(n, 100);
      check("t6_ready", ready, 1);

      // random lock activity and stray clears, checked by the model every cycle
      for (int r = 0; r < 4; r++) begin
         do_reset("rnd_rst");
         for (int c = 0; c < 500; c++) begin
            if ($urandom_range(0, 15) == 0) dcm_locked = ~dcm_locked;
            fault_clr = ($urandom_range(0, 31) == 0);
            tick(1);
         end
         fault_clr = 1'b0;
      end

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
